// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout tally: FSM states, price table,
// expensive-item codes and a saturating two-digit BCD increment.
package checkout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD_D0 = 2'd1,
    ST_ADD_D1 = 2'd2,
    ST_ADD_D2 = 2'd3
  } state_t;

  // Items that trip the alarm when scanned without the paid mark
  localparam logic [2:0] UPC_EXP_A = 3'b110;
  localparam logic [2:0] UPC_EXP_B = 3'b111;

  localparam logic [7:0] BCD_COUNT_MAX = 8'h99;

  // Two-digit BCD price in dollars; the hundreds digit is always zero
  function automatic logic [7:0] price_of(input logic [2:0] upc);
    logic [7:0] p;
    case (upc)
      3'b000:  p = 8'h12;
      3'b001:  p = 8'h05;
      3'b010:  p = 8'h03;
      3'b011:  p = 8'h40;
      3'b100:  p = 8'h08;
      3'b101:  p = 8'h25;
      3'b110:  p = 8'h99;
      default: p = 8'h60;
    endcase
    return p;
  endfunction

  function automatic logic is_expensive(input logic [2:0] upc);
    return (upc == UPC_EXP_A) || (upc == UPC_EXP_B);
  endfunction

  // Two-digit BCD increment that sticks at 99
  function automatic logic [7:0] bcd2_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_COUNT_MAX)     r = v;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: a + b + cin -> one decimal digit plus carry.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary add, then fold anything above 9 back into 0..9 with a carry
  always_comb begin
    raw = 5'(a) + 5'(b) + 5'(cin);
    if (raw > 5'd9) begin
      sum  = 4'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/checkout_tally.sv
// Checkout register: adds item prices into a 3-digit BCD total one digit per
// cycle through a single shared digit adder, counts items, flags theft/overflow.
module checkout_tally (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan,
  input  logic [2:0]  upc,
  input  logic        marked,
  input  logic        clear,
  output logic [11:0] total_bcd,
  output logic [7:0]  item_count_bcd,
  output logic        busy,
  output logic        stolen,
  output logic        ovf
);

  import checkout_pkg::*;

  state_t          state_reg, state_next;
  logic            prev_scan_reg;
  logic            armed_reg;      // set once scan has been seen low since reset
  logic [7:0]      price_reg;
  logic            carry_reg;
  logic            stolen_reg;
  logic            ovf_reg;
  logic [7:0]      count_reg;
  logic [2:0][3:0] total_digits;

  logic            add_active;
  logic [1:0]      digit_idx;
  logic            accept;
  logic            steal;
  logic [3:0]      add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  // A scan held high through reset must fall before it counts, hence armed_reg
  assign accept = scan && !prev_scan_reg && armed_reg && (state_reg == ST_IDLE) && !clear;
  assign steal  = is_expensive(upc) && !marked;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: clear aborts; otherwise walk the three digit states
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (accept && !steal) state_next = ST_ADD_D0;
        ST_ADD_D0: state_next = ST_ADD_D1;
        ST_ADD_D1: state_next = ST_ADD_D2;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs of the FSM: busy plus which total digit the adder works on
  always_comb begin
    busy       = 1'b0;
    add_active = 1'b0;
    digit_idx  = 2'd0;
    case (state_reg)
      ST_ADD_D0: begin busy = 1'b1; add_active = 1'b1; digit_idx = 2'd0; end
      ST_ADD_D1: begin busy = 1'b1; add_active = 1'b1; digit_idx = 2'd1; end
      ST_ADD_D2: begin busy = 1'b1; add_active = 1'b1; digit_idx = 2'd2; end
      default:   ;
    endcase
  end

  // Operand steering for the shared adder; hundreds of the price is zero
  always_comb begin
    case (digit_idx)
      2'd0:    begin add_a = total_digits[0]; add_b = price_reg[3:0]; add_cin = 1'b0;      end
      2'd1:    begin add_a = total_digits[1]; add_b = price_reg[7:4]; add_cin = carry_reg; end
      default: begin add_a = total_digits[2]; add_b = 4'd0;           add_cin = carry_reg; end
    endcase
  end

  bcd_digit_add u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Control/status registers: edge detect, price latch, carry, flags, count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_scan_reg <= 1'b0;
      armed_reg     <= 1'b0;
      price_reg     <= '0;
      carry_reg     <= 1'b0;
      stolen_reg    <= 1'b0;
      ovf_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      prev_scan_reg <= scan;
      if (!scan) armed_reg <= 1'b1;
      if (clear) begin
        carry_reg  <= 1'b0;
        stolen_reg <= 1'b0;
        ovf_reg    <= 1'b0;
        count_reg  <= '0;
      end else begin
        if (accept && steal)  stolen_reg <= 1'b1;
        if (accept && !steal) price_reg  <= price_of(upc);
        if (add_active)       carry_reg  <= add_cout;
        if (state_reg == ST_ADD_D2) begin
          count_reg <= bcd2_inc_sat(count_reg);
          if (add_cout) ovf_reg <= 1'b1;
        end
      end
    end
  end

  // One register per total digit; a hundreds carry pins every digit to 9
  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    logic [3:0] digit_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        digit_reg <= '0;
      end else if (clear) begin
        digit_reg <= '0;
      end else if (add_active && !ovf_reg) begin
        if (digit_idx == 2'd2 && add_cout) digit_reg <= 4'd9;
        else if (digit_idx == 2'(gi))      digit_reg <= add_sum;
      end
    end
    assign total_digits[gi] = digit_reg;
  end

  assign total_bcd      = total_digits;
  assign item_count_bcd = count_reg;
  assign stolen         = stolen_reg;
  assign ovf            = ovf_reg;

endmodule

// File: tb/tb_checkout_tally.sv
// Self-checking bench for checkout_tally: model predicts totals on each scan,
// results queued and compared when the addition finishes.
module tb_checkout_tally;

  logic        clk = 1'b0;
  logic        reset, scan, marked, clear;
  logic [2:0]  upc;
  logic [11:0] total_bcd;
  logic [7:0]  item_count_bcd;
  logic        busy, stolen, ovf;

  int checks = 0;
  int errors = 0;

  int price_tbl [8] = '{12, 5, 3, 40, 8, 25, 99, 60};
  int m_total, m_count;
  bit m_stolen, m_ovf;

  typedef struct {
    string       name;
    logic [11:0] total;
    logic [7:0]  count;
    logic        stolen;
    logic        ovf;
    int          busy_cycles;   // -1: not compared
  } exp_t;
  exp_t sb_q[$];

  checkout_tally dut (
    .clk            (clk),
    .reset          (reset),
    .scan           (scan),
    .upc            (upc),
    .marked         (marked),
    .clear          (clear),
    .total_bcd      (total_bcd),
    .item_count_bcd (item_count_bcd),
    .busy           (busy),
    .stolen         (stolen),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] to_bcd3(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_clear();
    m_total = 0; m_count = 0; m_stolen = 0; m_ovf = 0;
  endtask

  task automatic model_scan(input logic [2:0] u, input logic mk, input string name);
    exp_t e;
    int   bc;
    if ((u == 3'b110 || u == 3'b111) && !mk) begin
      m_stolen = 1;
      bc = 0;
    end else begin
      m_total += price_tbl[u];
      if (m_total > 999) begin m_total = 999; m_ovf = 1; end
      if (m_count < 99) m_count++;
      bc = 3;
    end
    e.name = name; e.total = to_bcd3(m_total); e.count = to_bcd2(m_count);
    e.stolen = m_stolen; e.ovf = m_ovf; e.busy_cycles = bc;
    sb_q.push_back(e);
  endtask

  // Wait for the addition to finish (bounded), then score against the queue head
  task automatic wait_result();
    exp_t e;
    int   n = 0;
    while (busy === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required low within 3", n);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    if (total_bcd !== e.total) begin
      errors++; $display("FAIL %s total: got %h required %h", e.name, total_bcd, e.total);
    end
    checks++;
    if (item_count_bcd !== e.count) begin
      errors++; $display("FAIL %s count: got %h required %h", e.name, item_count_bcd, e.count);
    end
    checks++;
    if (stolen !== e.stolen) begin
      errors++; $display("FAIL %s stolen: got %b required %b", e.name, stolen, e.stolen);
    end
    checks++;
    if (ovf !== e.ovf) begin
      errors++; $display("FAIL %s ovf: got %b required %b", e.name, ovf, e.ovf);
    end
    if (e.busy_cycles >= 0) begin
      checks++;
      if (n !== e.busy_cycles) begin
        errors++; $display("FAIL %s busy_cycles: got %0d required %0d", e.name, n, e.busy_cycles);
      end
    end
    $display("txn %s: total=%h count=%h stolen=%b ovf=%b busy_cycles=%0d", e.name,
             total_bcd, item_count_bcd, stolen, ovf, n);
  endtask

  task automatic scan_item(input logic [2:0] u, input logic mk, input string name);
    @(negedge clk);
    scan = 1'b1; upc = u; marked = mk;
    model_scan(u, mk, name);
    @(negedge clk);
    scan = 1'b0;
    wait_result();
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; scan = 1'b0; clear = 1'b0; upc = '0; marked = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++; if (total_bcd !== 12'h000) begin errors++; $display("FAIL reset_total: got %h required 000", total_bcd); end
    checks++; if (item_count_bcd !== 8'h00) begin errors++; $display("FAIL reset_count: got %h required 00", item_count_bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (stolen !== 1'b0) begin errors++; $display("FAIL reset_stolen: got %b required 0", stolen); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf); end
    $display("txn reset: total=%h count=%h busy=%b", total_bcd, item_count_bcd, busy);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    scan_item(3'b001, 1'b0, "basic_001");
    scan_item(3'b011, 1'b0, "basic_011");
  endtask

  task automatic test_stolen();
    do_clear();
    scan_item(3'b110, 1'b0, "stolen_unmarked");
    scan_item(3'b110, 1'b1, "stolen_marked");
    scan_item(3'b111, 1'b0, "stolen_111_unmarked");
    do_clear();
    @(negedge clk);
    checks++; if (stolen !== 1'b0) begin errors++; $display("FAIL stolen_after_clear: got %b required 0", stolen); end
    $display("txn stolen_clear: stolen=%b", stolen);
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 11; i++) scan_item(3'b110, 1'b1, $sformatf("ovf_scan%0d", i + 1));
    scan_item(3'b010, 1'b0, "ovf_after");
  endtask

  task automatic test_busy_drop();
    do_clear();
    @(negedge clk);
    scan = 1'b1; upc = 3'b000; marked = 1'b0;
    model_scan(3'b000, 1'b0, "busy_drop");
    sb_q[sb_q.size() - 1].busy_cycles = -1;
    @(negedge clk); scan = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_drop_d0: got %b required 1", busy); end
    @(negedge clk); scan = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_drop_d1: got %b required 1", busy); end
    @(negedge clk); scan = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_drop_d2: got %b required 1", busy); end
    wait_result();
    repeat (3) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_drop_idle: got %b required 0", busy); end
    end
    checks++; if (total_bcd !== 12'h012) begin errors++; $display("FAIL busy_drop_total: got %h required 012", total_bcd); end
  endtask

  task automatic test_clear_mid();
    do_clear();
    scan_item(3'b001, 1'b0, "clear_pre");
    @(negedge clk); scan = 1'b1; upc = 3'b000; marked = 1'b0;
    @(negedge clk); scan = 1'b0;            // ADD_D0
    @(negedge clk);                         // ADD_D1, ones digit already written
    checks++; if (total_bcd !== 12'h007) begin errors++; $display("FAIL clear_mid_partial: got %h required 007", total_bcd); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    checks++; if (total_bcd !== 12'h000) begin errors++; $display("FAIL clear_mid_total: got %h required 000", total_bcd); end
    checks++; if (item_count_bcd !== 8'h00) begin errors++; $display("FAIL clear_mid_count: got %h required 00", item_count_bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_mid_busy: got %b required 0", busy); end
    $display("txn clear_mid: total=%h count=%h busy=%b", total_bcd, item_count_bcd, busy);
    // Scan edge coincident with clear is discarded
    @(negedge clk); scan = 1'b1; upc = 3'b011; clear = 1'b1;
    @(negedge clk); scan = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_scan_busy: got %b required 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (total_bcd !== 12'h000) begin errors++; $display("FAIL clear_scan_total: got %h required 000", total_bcd); end
    checks++; if (item_count_bcd !== 8'h00) begin errors++; $display("FAIL clear_scan_count: got %h required 00", item_count_bcd); end
    $display("txn clear_with_scan: total=%h count=%h", total_bcd, item_count_bcd);
  endtask

  task automatic test_reset_mid();
    scan_item(3'b101, 1'b0, "reset_pre");
    @(negedge clk); scan = 1'b1; upc = 3'b001; marked = 1'b0;
    @(negedge clk);                          // ADD_D0, scan held high
    reset = 1'b1;
    #1;
    model_clear();
    checks++; if (total_bcd !== 12'h000) begin errors++; $display("FAIL reset_mid_total: got %h required 000", total_bcd); end
    checks++; if (item_count_bcd !== 8'h00) begin errors++; $display("FAIL reset_mid_count: got %h required 00", item_count_bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b required 0", busy); end
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_held_busy: got %b required 0", busy); end
    end
    checks++; if (item_count_bcd !== 8'h00) begin errors++; $display("FAIL reset_mid_held_count: got %h required 00", item_count_bcd); end
    $display("txn reset_mid: total=%h count=%h busy=%b", total_bcd, item_count_bcd, busy);
    scan = 1'b0;
    scan_item(3'b001, 1'b0, "reset_rearm");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stolen();
    test_overflow();
    test_busy_drop();
    test_clear_mid();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/checkout_tally.md
CHECKOUT_TALLY -- requirements
Module: checkout_tally

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 scan  input  1  item-scan request, level, already synchronized and active-high; the block edge-detects it.
REQ-004 upc  input  3  UPC code of the scanned item, sampled on the detected scan edge.
REQ-005 marked  input  1  item carries the paid/security mark, sampled with upc.
REQ-006 clear  input  1  level, active-high; start a new customer.
REQ-007 total_bcd  output  12  running total in dollars, 3 BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones.
REQ-008 item_count_bcd  output  8  items accepted, 2 BCD digits.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 stolen  output  1  sticky alarm: an expensive item was scanned unmarked.
REQ-011 ovf  output  1  sticky: total saturated.

Function
REQ-012 Scan edge SHALL be scan=1 with the registered previous scan=0, evaluated only in IDLE; edges while busy SHALL be dropped, not queued.
REQ-013 Price table (BCD dollars), indexed by upc: 000=12, 001=05, 010=03, 011=40, 100=08, 101=25, 110=99, 111=60; UPC 110 and 111 SHALL be expensive.
REQ-014 On an accepted edge with an expensive upc and marked=0: stolen SHALL set; total and count SHALL be unchanged; state SHALL remain IDLE.
REQ-015 Otherwise the price SHALL be latched and the FSM SHALL step IDLE -> ADD_D0 -> ADD_D1 -> ADD_D2 -> IDLE, one state per cycle.
REQ-016 ADD_D0/ADD_D1/ADD_D2 SHALL write the ones/tens/hundreds digit respectively using BCD digit addition with carry propagated between states; the price hundreds digit is 0.
REQ-017 busy SHALL be high exactly in the three ADD states; updated total and count SHALL be visible the cycle after ADD_D2 (3 cycles after the detecting edge).
REQ-018 item_count_bcd SHALL increment on the ADD_D2 -> IDLE transition and saturate at 99.
REQ-019 A carry out of the hundreds digit SHALL force total_bcd to 999 and set ovf.
REQ-020 Once ovf is set, further additions SHALL leave total at 999 while still incrementing count.
REQ-021 clear SHALL have priority over everything: total, count, stolen, ovf to 0, FSM to IDLE, aborting any in-progress addition with no partial digit retained.
REQ-022 Scan edge and clear in the same cycle: clear wins; the scan edge is discarded.

Reset
REQ-023 reset SHALL asynchronously force total_bcd=0, item_count_bcd=0, busy=0, stolen=0, ovf=0, FSM=IDLE, previous-scan register=0.
REQ-024 Reset asserted mid-addition SHALL discard the addition; after release a scan held high SHALL NOT count until it falls and rises again.

Structure
REQ-025 Package checkout_pkg SHALL hold the FSM state enum, the UPC price table, and the expensive-UPC constants.
REQ-026 One sub-module, bcd_digit_add (4-bit digit + digit + carry-in -> digit + carry-out, combinational), SHALL be instantiated once and shared across the ADD states.

Verification
REQ-027 Scan upc=001 marked=0, then upc=011 -> total 045, count 01 then 02, busy high 3 cycles per scan.
REQ-028 Scan upc=110 marked=0 -> stolen=1, total/count unchanged; repeat with marked=1 -> total 099 added, stolen stays 1 until clear.
REQ-029 Eleven scans of upc=110 marked=1 -> total 999 after the 11th, ovf=1, count 11.
REQ-030 Raise scan again during busy -> ignored; total reflects a single item.
REQ-031 Assert clear during ADD_D1 of upc=000 -> next cycle total 000, count 00, busy 0.
REQ-032 Assert reset mid-addition with scan held high -> all outputs 0; no count until scan toggles.
